// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: two requesting masters and one single-port RAM.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [MASK_W-1:0] m0_wmask;
  logic              m0_rstrb;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [MASK_W-1:0] m1_wmask;
  logic              m1_rstrb;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    output m0_rdata, m0_ack,
    input  m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    output m1_rdata, m1_ack,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata
  );

  modport master (
    output m0_addr, m0_wdata, m0_wmask, m0_rstrb,
    input  m0_rdata, m0_ack,
    output m1_addr, m1_wdata, m1_wmask, m1_rstrb,
    input  m1_rdata, m1_ack,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter onto one RAM port; issue -> wait -> ack, three cycles per transaction.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests; default is fixed priority (master 0).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_owner;
  logic              r_last_grant;
  logic              r_rd;
  logic              r_m0_ack;
  logic              r_m1_ack;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_req0;
  logic              w_req1;
  logic              w_grant;
  logic              w_issue;
  logic              w_sel;
  logic              w_sel_rstrb;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [MASK_W-1:0] w_wmask;

  assign w_req0 = bus.m0_rstrb | (|bus.m0_wmask);
  assign w_req1 = bus.m1_rstrb | (|bus.m1_wmask);

  // Arbitration between simultaneous requests; a lone request always wins.
  always_comb begin
    w_grant = 1'b0;
    if (w_req0 && w_req1) begin
`ifdef MEM_ARBITER_RR_EN
      w_grant = ~r_last_grant;
`else
      w_grant = 1'b0;
`endif
    end else if (w_req1) begin
      w_grant = 1'b1;
    end else begin
      w_grant = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_req0 || w_req1) && !rst) begin
          w_issue      = 1'b1;
          w_next_state = S_WAIT;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_WAIT:  w_next_state = S_ACK;
      S_ACK:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Address/data follow the owner; strobes exist only in the issue cycle.
  always_comb begin
    w_sel       = (r_state == S_IDLE) ? w_grant : r_owner;
    w_addr      = w_sel ? bus.m1_addr  : bus.m0_addr;
    w_wdata     = w_sel ? bus.m1_wdata : bus.m0_wdata;
    w_sel_rstrb = w_sel ? bus.m1_rstrb : bus.m0_rstrb;
    if (w_issue) begin
      w_wmask = w_sel ? bus.m1_wmask : bus.m0_wmask;
    end else begin
      w_wmask = {MASK_W{1'b0}};
    end
  end

  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;
  assign bus.mem_wmask = w_wmask;
  assign bus.mem_rstrb = w_issue & w_sel_rstrb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd         <= 1'b0;
    end else if (w_issue) begin
      r_owner      <= w_grant;
      r_last_grant <= w_grant;
      r_rd         <= w_sel_rstrb;
    end
  end

  // Ack is set on leaving WAIT so it is high exactly during ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_rdata <= {DATA_W{1'b0}};
      r_m1_rdata <= {DATA_W{1'b0}};
    end else begin
      r_m0_ack <= (r_state == S_WAIT) && !r_owner;
      r_m1_ack <= (r_state == S_WAIT) && r_owner;
      if ((r_state == S_WAIT) && r_rd) begin
        if (r_owner) begin
          r_m1_rdata <= bus.mem_rdata;
        end else begin
          r_m0_rdata <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.m0_ack   = r_m0_ack;
  assign bus.m1_ack   = r_m1_ack;
  assign bus.m0_rdata = r_m0_rdata;
  assign bus.m1_rdata = r_m1_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency RAM model.
// Round-robin expectations apply when MEM_ARBITER_RR_EN is defined.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] ram [0:63];
  logic [31:0] r_ram_q;

  // RAM model: read-before-write, contents reloaded while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[4]  <= 32'hDEADBEEF;
      ram[12] <= 32'hCAFEF00D;
      r_ram_q <= 32'h0;
    end else begin
      if (bus.mem_rstrb) r_ram_q <= ram[bus.mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wmask[b]) ram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end
  assign bus.mem_rdata = r_ram_q;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic drive(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input logic rstrb);
    if (m == 0) begin
      bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_wmask = wmask; bus.m0_rstrb = rstrb;
    end else begin
      bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_wmask = wmask; bus.m1_rstrb = rstrb;
    end
  endtask

  task automatic drop(input int m);
    drive(m, 32'h0, 32'h0, 4'h0, 1'b0);
  endtask

  // One complete transaction from an IDLE cycle; ends with the request dropped.
  task automatic run_txn(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic rstrb, input string tag);
    drive(m, addr, wdata, wmask, rstrb);
    at_sample();
    chk_eq({tag, " issue rstrb"}, 64'(bus.mem_rstrb), 64'(rstrb));
    chk_eq({tag, " issue wmask"}, 64'(bus.mem_wmask), 64'(wmask));
    chk_eq({tag, " issue addr"},  64'(bus.mem_addr),  64'(addr));
    chk_eq({tag, " issue wdata"}, 64'(bus.mem_wdata), 64'(wdata));
    next_cycle(); at_sample();
    chk_eq({tag, " wait strobes"}, 64'({bus.mem_rstrb, bus.mem_wmask}), 64'h0);
    chk_eq({tag, " wait acks"},    64'({bus.m0_ack, bus.m1_ack}), 64'h0);
    next_cycle(); at_sample();
    chk_eq({tag, " ack pair"}, 64'({bus.m0_ack, bus.m1_ack}), (m == 0) ? 64'h2 : 64'h1);
    chk_eq({tag, " ack strobes"}, 64'({bus.mem_rstrb, bus.mem_wmask}), 64'h0);
    next_cycle();
    drop(m);
  endtask

  initial begin
    drop(0); drop(1);
    rst = 1'b1;
    next_cycle(); next_cycle();
    bus.m0_rstrb = 1'b1;
    at_sample();
    chk_eq("reset acks",    64'({bus.m0_ack, bus.m1_ack}), 64'h0);
    chk_eq("reset m0_rdata", 64'(bus.m0_rdata), 64'h0);
    chk_eq("reset m1_rdata", 64'(bus.m1_rdata), 64'h0);
    chk_eq("reset strobes", 64'({bus.mem_rstrb, bus.mem_wmask}), 64'h0);
    next_cycle();
    drop(0);
    rst = 1'b0;

    // m0 read of preloaded word
    run_txn(0, 32'h10, 32'h0, 4'h0, 1'b1, "m0 read");
    chk_eq("m0 read rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
    chk_eq("m0 read m1_rdata", 64'(bus.m1_rdata), 64'h0);

    // m1 partial write leaves its rdata untouched
    run_txn(1, 32'h20, 32'h12345678, 4'b0011, 1'b0, "m1 write");
    chk_eq("m1 write rdata", 64'(bus.m1_rdata), 64'h0);
    chk_eq("m1 write ram", 64'(ram[8]), 64'h00005678);

    // read+write together captures the old word; write-only keeps rdata
    run_txn(0, 32'h20, 32'hAABBCCDD, 4'hF, 1'b1, "m0 rw");
    chk_eq("m0 rw rdata", 64'(bus.m0_rdata), 64'h00005678);
    run_txn(0, 32'h24, 32'h11111111, 4'hF, 1'b0, "m0 wr");
    chk_eq("m0 wr rdata held", 64'(bus.m0_rdata), 64'h00005678);

    // request held one IDLE cycle past ack is a new transaction
    drive(0, 32'h10, 32'h0, 4'h0, 1'b1);
    at_sample(); chk_eq("hold issue1", 64'(bus.mem_rstrb), 64'h1);
    next_cycle(); next_cycle(); at_sample();
    chk_eq("hold ack1", 64'(bus.m0_ack), 64'h1);
    next_cycle(); at_sample();
    chk_eq("hold issue2", 64'(bus.mem_rstrb), 64'h1);
    chk_eq("hold ack low", 64'(bus.m0_ack), 64'h0);
    next_cycle(); next_cycle(); at_sample();
    chk_eq("hold ack2", 64'(bus.m0_ack), 64'h1);
    chk_eq("hold rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
    next_cycle(); drop(0);

    // m1 arrives during m0 WAIT and is served after m0's ack
    drive(0, 32'h30, 32'h0, 4'h0, 1'b1);
    at_sample(); chk_eq("late issue m0", 64'(bus.mem_addr), 64'h30);
    next_cycle();
    drive(1, 32'h40, 32'h55AA55AA, 4'b1100, 1'b0);
    at_sample();
    chk_eq("late wait wmask", 64'(bus.mem_wmask), 64'h0);
    next_cycle(); at_sample();
    chk_eq("late m0 ack pair", 64'({bus.m0_ack, bus.m1_ack}), 64'h2);
    chk_eq("late m0 rdata", 64'(bus.m0_rdata), 64'hCAFEF00D);
    next_cycle(); drop(0);
    at_sample();
    chk_eq("late m1 issue wmask", 64'(bus.mem_wmask), 64'hC);
    chk_eq("late m1 issue addr", 64'(bus.mem_addr), 64'h40);
    next_cycle(); next_cycle(); at_sample();
    chk_eq("late m1 ack pair", 64'({bus.m0_ack, bus.m1_ack}), 64'h1);
    next_cycle(); drop(1);

    // reset in WAIT aborts the read; the held request re-issues afterwards
    drive(0, 32'h10, 32'h0, 4'h0, 1'b1);
    at_sample(); chk_eq("abort issue", 64'(bus.mem_rstrb), 64'h1);
    next_cycle(); at_sample();
    rst = 1'b1;
    #1;
    chk_eq("abort async m0_rdata", 64'(bus.m0_rdata), 64'h0);
    chk_eq("abort async acks", 64'({bus.m0_ack, bus.m1_ack}), 64'h0);
    chk_eq("abort async strobes", 64'({bus.mem_rstrb, bus.mem_wmask}), 64'h0);
    next_cycle(); at_sample();
    chk_eq("abort no ack", 64'(bus.m0_ack), 64'h0);
    next_cycle();
    rst = 1'b0;
    at_sample();
    chk_eq("abort reissue", 64'(bus.mem_rstrb), 64'h1);
    next_cycle(); next_cycle(); at_sample();
    chk_eq("abort reissue ack", 64'(bus.m0_ack), 64'h1);
    chk_eq("abort reissue rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
    next_cycle(); drop(0);

    // both masters reading continuously, starting from reset state
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(0, 32'h10, 32'h0, 4'h0, 1'b1);
    drive(1, 32'h30, 32'h0, 4'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      int g;
`ifdef MEM_ARBITER_RR_EN
      g = i % 2;
`else
      g = 0;
`endif
      at_sample();
      chk_eq($sformatf("both issue %0d", i), 64'(bus.mem_addr), (g == 1) ? 64'h30 : 64'h10);
      next_cycle(); next_cycle(); at_sample();
      chk_eq($sformatf("both ack %0d", i), 64'({bus.m0_ack, bus.m1_ack}), (g == 1) ? 64'h1 : 64'h2);
      chk_eq($sformatf("both rdata %0d", i), (g == 1) ? 64'(bus.m1_rdata) : 64'(bus.m0_rdata),
             (g == 1) ? 64'hCAFEF00D : 64'hDEADBEEF);
      next_cycle();
    end
    drop(0); drop(1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of all address ports.
REQ-002 Parameter DATA_W, default 32, width of all data ports (wmask width DATA_W/8).
REQ-003 clk  input  1  system clock, all state updates on rising edge; the design has one clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m0_addr  input  ADDR_W  master 0 (CPU) byte address.
REQ-006 m0_wdata  input  DATA_W  master 0 write data.
REQ-007 m0_wmask  input  4  master 0 byte write enables.
REQ-008 m0_rstrb  input  1  master 0 read strobe.
REQ-009 m0_rdata  output  DATA_W  master 0 read data, registered.
REQ-010 m0_ack  output  1  master 0 transaction complete, one-cycle pulse.
REQ-011 m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_rdata, m1_ack: same as m0_*, for master 1 (UART loader).
REQ-012 mem_addr  output  ADDR_W, mem_wdata  output  DATA_W, mem_wmask  output  4, mem_rstrb  output  1: RAM port.
REQ-013 mem_rdata  input  DATA_W  RAM read data, valid one cycle after mem_rstrb.

Function
REQ-014 Master request mN_req = mN_rstrb | (|mN_wmask); level-sensitive; master holds addr/wdata/wmask/rstrb stable until mN_ack.
REQ-015 FSM states IDLE, WAIT, ACK plus 1-bit owner register and 1-bit last_grant register.
REQ-016 IDLE: no request -> stay IDLE, mem_rstrb=0, mem_wmask=0.
REQ-017 IDLE with request(s): select owner per REQ-024/025, drive mem_* combinationally from owner in this cycle (issue cycle), go WAIT, last_grant<=owner.
REQ-018 mem_rstrb and mem_wmask SHALL be nonzero only in the issue cycle; mem_addr/mem_wdata follow the owner (or master 0 when idle).
REQ-019 WAIT: if the owner's request had rstrb=1, mN_rdata<=mem_rdata at the end of the cycle; go ACK.
REQ-020 ACK: mN_ack=1 for owner only, other ack 0; go IDLE unconditionally.
REQ-021 Latency: issue at cycle N, ack at cycle N+2; max throughput one transaction per 3 cycles.
REQ-022 Write-only transaction (rstrb=0) SHALL leave mN_rdata unchanged; read+write together passes both strobes, rdata is captured.
REQ-023 Master sampling its ack high SHALL drop or change its request on that edge; a request still present in the following IDLE cycle is a new transaction.
REQ-024 Non-owner requests arriving during WAIT/ACK SHALL wait, unacknowledged, until the next IDLE cycle.
REQ-025 Simultaneous requests in IDLE: arbitration per Configuration; a single request is always granted immediately.
REQ-026 mN_rdata holds its last captured value indefinitely.

Reset
REQ-027 rst high SHALL immediately force state IDLE, owner=0, last_grant=1, m0_ack=m1_ack=0, m0_rdata=m1_rdata=0, mem_rstrb=0, mem_wmask=0, regardless of transaction in progress.
REQ-028 A transaction interrupted by reset SHALL never be acknowledged; masters re-issue after reset release.

Configuration
REQ-029 Macro MEM_ARBITER_RR_EN defined: round-robin; on simultaneous requests grant master != last_grant (master 0 wins first after reset).
REQ-030 Macro MEM_ARBITER_RR_EN undefined: fixed priority, master 0 always wins simultaneous requests; last_grant still maintained but unused.

Verification
REQ-031 m0 read addr 0x10, RAM[0x10]=0xDEADBEEF -> mem_rstrb one cycle at N, m0_ack at N+2, m0_rdata=0xDEADBEEF, m1_ack stays 0.
REQ-032 m1 write addr 0x20 wdata 0x12345678 wmask 4'b0011 -> mem_wmask=4'b0011 only in issue cycle, m1_ack at N+2, m1_rdata unchanged (0 after reset).
REQ-033 Both masters request reads continuously, RR_EN defined -> grants alternate 0,1,0,1 every 3 cycles; RR_EN undefined -> m0 served every transaction while it keeps requesting.
REQ-034 m1 requests during m0's WAIT cycle -> m1 issued in first IDLE after m0_ack, acked 2 cycles later.
REQ-035 rst asserted in WAIT of m0 read -> outputs go to reset values asynchronously, no m0_ack; after release, re-issued read completes normally.
REQ-036 Master holds request one extra IDLE cycle after ack -> second mem_rstrb pulse and second ack observed (new transaction).
